bus_access_sequencer: RTL and testbench
=======================================

Name: bus_access_sequencer

Overview:
- Sequences every access on the shared system bus after address decode.
- Arbitrates between the CPU and DMA requesters and steers the winner's address into the chip-select decoder.
- Holds the decoded chip-select vector for the programmed per-region wait-state count, then completes the access with a one-cycle ack, or with a one-cycle error when the decoder flags a bus error.
- Sits between the CPU/DMA bus masters and the chip-select decoder plus peripheral chip-select fan-out.

Parameters:
RAM_DELAY, 2, wait cycles for RAM and RAMHIZ accesses
IO_DELAY, 1, wait cycles for internal I/O blocks (MemCtrl1/2, PeriphIO, INT, DMA, Timer, GPU, MDEC)
CS_W, 14, width of the chip-select vector (bit order RAMHIZ=13 .. BIOS_CS=0)

Ports:
i_clk  in  1  system clock
i_nrst  in  1  synchronous active-low reset
i_cpuReq  in  1  CPU access request, held high until ack/err
i_dmaReq  in  1  DMA access request, held high until ack/err
o_addrSel  out  1  registered decoder address mux select: 0=CPU, 1=DMA
i_csPins  in  CS_W  chip-select vector from decoder for the selected address
i_busError  in  1  decoder bus-error flag for the selected address
i_dlyBIOS  in  4  BIOS access wait cycles
i_dlyCDRM  in  4  CD-ROM access wait cycles
i_dlySPU  in  4  SPU access wait cycles
i_dlyExp2  in  4  Expansion region 2 access wait cycles
o_csStrobe  out  CS_W  registered chip select to peripherals, valid in WAIT and DONE
o_busy  out  1  high whenever the state is not IDLE
o_cpuAck  out  1  one-cycle completion pulse to the CPU
o_dmaAck  out  1  one-cycle completion pulse to DMA
o_cpuErr  out  1  one-cycle bus-error pulse to the CPU
o_dmaErr  out  1  one-cycle bus-error pulse to DMA

Behaviour:
- Reset (i_nrst=0 at a clock edge):
  - State goes to IDLE.
  - o_addrSel=0, o_csStrobe=0, o_busy=0, all ack/err outputs=0.
  - Internal lastOwner=1 (DMA), so the CPU wins the first tie.
  - Reset mid-access aborts the access with no ack or err pulse; the requester re-requests.
- States: IDLE, DECODE, WAIT, DONE, ERR.
- IDLE:
  - Either request high: register the winner into o_addrSel and go to DECODE.
  - Only one request high: that requester wins.
  - Both high: the requester other than lastOwner wins (round-robin).
  - No request: stay in IDLE.
- DECODE (one cycle; the decoder sees the stable muxed address):
  - Sample i_busError and i_csPins.
  - i_busError=1: go to ERR, o_csStrobe stays 0.
  - Otherwise latch i_csPins into o_csStrobe and load the wait counter with the delay below.
  - Delay selection, priority order:
    - RAM or RAMHIZ -> RAM_DELAY
    - BIOS_CS -> i_dlyBIOS
    - CDRomCtrl -> i_dlyCDRM
    - SPUCtrl -> i_dlySPU
    - ExpReg2 -> i_dlyExp2
    - any other bit -> IO_DELAY
  - Delay 0: go to DONE. Otherwise go to WAIT.
- WAIT:
  - Counter decrements by 1 per cycle.
  - On the cycle it reads 1, go to DONE.
  - Occupancy in WAIT is therefore exactly delay cycles.
  - o_csStrobe is held throughout.
- DONE (one cycle):
  - Pulse the owner's ack, hold o_csStrobe, set lastOwner to the owner.
  - Next state IDLE; o_csStrobe is cleared on entering IDLE.
- ERR (one cycle):
  - Pulse the owner's err and update lastOwner.
  - Next state IDLE.
- Latency: request seen in IDLE, then ack/err is 2+delay cycles later.
  - Ack with delay d asserts on cycle 2+d after the request cycle.
  - Err asserts on cycle 2.
- Requester behaviour:
  - A requester must drop its request in the cycle after ack/err; otherwise it is re-arbitrated as a new access.
  - A request dropped mid-access is ignored; the access completes and the pulse is still issued.
- No back-to-back grant: IDLE always spends at least one cycle between accesses.
- i_csPins and the delay inputs are sampled only in DECODE. Changes during WAIT have no effect.
- Multiple cs bits set (decoder fault): resolved by the priority order above; all set bits are strobed.
- Delay 15: 15 WAIT cycles; the counter never wraps.
- o_busy is high in DECODE, WAIT, DONE and ERR.

Test Plan:
- CPU-only RAM access, RAM_DELAY=2: i_cpuReq high at cycle 0 -> o_addrSel=0, o_csStrobe=0x1000 in cycles 2-4, o_cpuAck=1 only at cycle 4, o_dmaAck never.
- Simultaneous cpu/dma requests after reset: CPU is granted first. DMA is granted on the next IDLE, with o_addrSel=1. A further tie grants the CPU again (round-robin).
- BIOS access, i_dlyBIOS=0: ack at cycle 2, zero WAIT cycles. Same test with i_dlyBIOS=15: ack at cycle 17.
- DMA request with i_busError=1: o_dmaErr pulses at cycle 2, o_csStrobe stays 0, o_dmaAck never asserts, state returns to IDLE.
- i_nrst low during WAIT of an SPU access (i_dlySPU=6): all outputs 0 on the next edge, no ack. After reset release with the request still held, the access restarts and acks 8 cycles after the request is seen in IDLE.
- Delay input changes mid-WAIT (i_dlyCDRM 3 -> 9 at cycle 3): ack still at cycle 5.

Source files
------------

// File: rtl/bus_access_sequencer.sv
// bus_access_sequencer
//   Sequences one system-bus access at a time after address decode:
//   round-robin CPU/DMA arbitration, a one-cycle decode slot, a per-region
//   wait-state hold of the chip selects, then a one-cycle ack or err pulse.
// Ports:
//   i_clk, i_nrst              clock, synchronous active-low reset
//   i_cpuReq, i_dmaReq         requests, held until ack/err
//   o_addrSel                  decoder address mux select (0=CPU, 1=DMA)
//   i_csPins, i_busError       decoder result for the selected address
//   i_dlyBIOS/CDRM/SPU/Exp2    programmable wait counts for those regions
//   o_csStrobe                 chip selects to peripherals (WAIT and DONE)
//   o_busy                     access in progress
//   o_cpuAck/o_dmaAck          completion pulses
//   o_cpuErr/o_dmaErr          bus-error pulses
// Chip-select bit map: 0 BIOS, 1 MemCtrl1, 2 PeriphIO, 3 MemCtrl2, 4 INT,
//   5 DMA, 6 Timer, 7 CDRomCtrl, 8 GPU, 9 MDEC, 10 SPUCtrl, 11 ExpReg2,
//   12 RAM, 13 RAMHIZ.
module bus_access_sequencer #(
  parameter int RAM_DELAY = 2,
  parameter int IO_DELAY  = 1,
  parameter int CS_W      = 14
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic            i_cpuReq,
  input  logic            i_dmaReq,
  output logic            o_addrSel,
  input  logic [CS_W-1:0] i_csPins,
  input  logic            i_busError,
  input  logic [3:0]      i_dlyBIOS,
  input  logic [3:0]      i_dlyCDRM,
  input  logic [3:0]      i_dlySPU,
  input  logic [3:0]      i_dlyExp2,
  output logic [CS_W-1:0] o_csStrobe,
  output logic            o_busy,
  output logic            o_cpuAck,
  output logic            o_dmaAck,
  output logic            o_cpuErr,
  output logic            o_dmaErr
);

  localparam int BIT_BIOS   = 0;
  localparam int BIT_CDRM   = 7;
  localparam int BIT_SPU    = 10;
  localparam int BIT_EXP2   = 11;
  localparam int BIT_RAM    = 12;
  localparam int BIT_RAMHIZ = 13;

  typedef enum logic [2:0] {IDLE, DECODE, WAIT, DONE, ERR} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       last_owner;
  logic [3:0] wait_dly;
  logic       winner;

  // Wait-count selection; a faulty multi-hot decode resolves by this order.
  always_comb begin
    wait_dly = 4'(IO_DELAY);
    if (i_csPins[BIT_RAM] || i_csPins[BIT_RAMHIZ]) wait_dly = 4'(RAM_DELAY);
    else if (i_csPins[BIT_BIOS])                   wait_dly = i_dlyBIOS;
    else if (i_csPins[BIT_CDRM])                   wait_dly = i_dlyCDRM;
    else if (i_csPins[BIT_SPU])                    wait_dly = i_dlySPU;
    else if (i_csPins[BIT_EXP2])                   wait_dly = i_dlyExp2;
  end

  // On a tie the requester that did not own the previous access wins.
  assign winner = (i_cpuReq && i_dmaReq) ? ~last_owner : i_dmaReq;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= 1'b1;
      o_addrSel  <= 1'b0;
      o_csStrobe <= '0;
      o_busy     <= 1'b0;
      o_cpuAck   <= 1'b0;
      o_dmaAck   <= 1'b0;
      o_cpuErr   <= 1'b0;
      o_dmaErr   <= 1'b0;
    end else begin
      o_cpuAck <= 1'b0;
      o_dmaAck <= 1'b0;
      o_cpuErr <= 1'b0;
      o_dmaErr <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cpuReq || i_dmaReq) begin
            o_addrSel <= winner;
            o_busy    <= 1'b1;
            state     <= DECODE;
          end
        end
        DECODE: begin
          if (i_busError) begin
            o_cpuErr <= ~o_addrSel;
            o_dmaErr <= o_addrSel;
            state    <= ERR;
          end else begin
            o_csStrobe <= i_csPins;
            cnt        <= wait_dly;
            if (wait_dly == 4'd0) begin
              o_cpuAck <= ~o_addrSel;
              o_dmaAck <= o_addrSel;
              state    <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // Ack is registered on the transition so it is high during DONE.
          if (cnt == 4'd1) begin
            o_cpuAck <= ~o_addrSel;
            o_dmaAck <= o_addrSel;
            state    <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          last_owner <= o_addrSel;
          o_csStrobe <= '0;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
        ERR: begin
          last_owner <= o_addrSel;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_access_sequencer.sv
module tb_bus_access_sequencer;

  localparam int CS_W = 14;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            cpuReq = 1'b0, dmaReq = 1'b0;
  logic            addrSel;
  logic [CS_W-1:0] csPins = '0;
  logic            busError = 1'b0;
  logic [3:0]      dlyBIOS = '0, dlyCDRM = '0, dlySPU = '0, dlyExp2 = '0;
  logic [CS_W-1:0] csStrobe;
  logic            busy, cpuAck, dmaAck, cpuErr, dmaErr;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  bus_access_sequencer #(.RAM_DELAY(2), .IO_DELAY(1), .CS_W(CS_W)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_cpuReq(cpuReq), .i_dmaReq(dmaReq),
    .o_addrSel(addrSel), .i_csPins(csPins), .i_busError(busError),
    .i_dlyBIOS(dlyBIOS), .i_dlyCDRM(dlyCDRM), .i_dlySPU(dlySPU),
    .i_dlyExp2(dlyExp2), .o_csStrobe(csStrobe), .o_busy(busy),
    .o_cpuAck(cpuAck), .o_dmaAck(dmaAck), .o_cpuErr(cpuErr), .o_dmaErr(dmaErr)
  );

  always #5 clk = ~clk;

  // Wait count for a decoded chip-select vector, from the region rules.
  function automatic int pick(input logic [CS_W-1:0] cs);
    if (cs[12] || cs[13]) return 2;
    if (cs[0])  return int'(dlyBIOS);
    if (cs[7])  return int'(dlyCDRM);
    if (cs[10]) return int'(dlySPU);
    if (cs[11]) return int'(dlyExp2);
    return 1;
  endfunction

  // Timeline model: an access starts on the cycle after the request is seen
  // (t=1 is the decode slot) and finishes at t = 2 (error) or 2 + delay.
  bit              m_act = 0, m_own = 0, m_last = 1, m_sel = 0, m_err = 0;
  int              m_t = 0, m_d = 0;
  logic [CS_W-1:0] m_cs = '0;

  always @(posedge clk) begin
    if (!nrst) begin
      m_act = 0; m_last = 1; m_sel = 0; m_t = 0; m_err = 0;
    end else if (m_act) begin
      if (m_t == 1) begin
        m_err = busError; m_cs = csPins; m_d = pick(csPins);
      end
      m_t++;
      if (m_t > (m_err ? 2 : 2 + m_d)) begin
        m_act = 0; m_last = m_own;
      end
    end else if (cpuReq || dmaReq) begin
      m_own = (cpuReq && dmaReq) ? !m_last : dmaReq;
      m_sel = m_own; m_act = 1; m_t = 1; m_err = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [CS_W-1:0] e_cs;
      bit e_busy, e_cack, e_dack, e_cerr, e_derr, fin;
      fin    = m_act && m_t >= 2 && m_t == (m_err ? 2 : 2 + m_d);
      e_busy = m_act;
      e_cs   = (m_act && m_t >= 2 && !m_err) ? m_cs : '0;
      e_cack = fin && !m_err && !m_own;
      e_dack = fin && !m_err && m_own;
      e_cerr = fin && m_err && !m_own;
      e_derr = fin && m_err && m_own;
      total++;
      if (addrSel !== m_sel || csStrobe !== e_cs || busy !== e_busy ||
          cpuAck !== e_cack || dmaAck !== e_dack || cpuErr !== e_cerr || dmaErr !== e_derr) begin
        bad++;
        $display("FAIL cycle t=%0t got sel=%b cs=%h busy=%b ack=%b%b err=%b%b want sel=%b cs=%h busy=%b ack=%b%b err=%b%b",
                 $time, addrSel, csStrobe, busy, cpuAck, dmaAck, cpuErr, dmaErr,
                 m_sel, e_cs, e_busy, e_cack, e_dack, e_cerr, e_derr);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    nrst = 0; cpuReq = 0; dmaReq = 0;
    tick(); tick();
    nrst = 1;
  endtask

  // Raises the selected requests in the current (idle) cycle = cycle 0, waits
  // for the first completion pulse, then drops the winner's request.
  task automatic access(input bit c, input bit d, input int chg, output int lat,
                        output bit who, output bit er, output bit sel1,
                        output logic [CS_W-1:0] s2);
    if (c) cpuReq = 1;
    if (d) dmaReq = 1;
    lat = -1; who = 0; er = 0; sel1 = 0; s2 = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 1) sel1 = addrSel;
      if (k == 2) s2 = csStrobe;
      if (cpuAck || cpuErr || dmaAck || dmaErr) begin
        lat = k; who = dmaAck || dmaErr; er = cpuErr || dmaErr;
        break;
      end
      if (k == chg) dlyCDRM = 4'd9;
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL access-timeout got=none want=pulse");
    end
    @(posedge clk); #1;
    if (who) dmaReq = 0; else cpuReq = 0;
  endtask

  initial begin
    int lat; bit who, er, sel1; logic [CS_W-1:0] s2;
    bit gc, gd;

    @(posedge clk); #1;
    chk_en = 1;
    do_reset();
    chk("reset-busy", int'(busy), 0);
    chk("reset-strobe", int'(csStrobe), 0);

    // CPU RAM access
    csPins = 14'h1000;
    access(1, 0, -1, lat, who, er, sel1, s2);
    chk("ram-lat", lat, 4); chk("ram-who", who, 0); chk("ram-sel", sel1, 0);
    chk("ram-strobe", int'(s2), 'h1000);
    tick();

    // Round-robin ties
    do_reset();
    access(1, 1, -1, lat, who, er, sel1, s2);
    chk("tie1-who", who, 0);
    access(0, 1, -1, lat, who, er, sel1, s2);
    chk("tie2-who", who, 1); chk("tie2-sel", sel1, 1); chk("tie2-lat", lat, 4);
    access(1, 1, -1, lat, who, er, sel1, s2);
    chk("tie3-who", who, 0);
    dmaReq = 0; tick();

    // BIOS with zero and maximum wait
    csPins = 14'h0001; dlyBIOS = 4'd0;
    access(1, 0, -1, lat, who, er, sel1, s2);
    chk("bios0-lat", lat, 2); chk("bios0-strobe", int'(s2), 1);
    tick();
    dlyBIOS = 4'd15;
    access(1, 0, -1, lat, who, er, sel1, s2);
    chk("bios15-lat", lat, 17);
    tick();

    // DMA bus error
    busError = 1; csPins = 14'h0020;
    access(0, 1, -1, lat, who, er, sel1, s2);
    chk("err-lat", lat, 2); chk("err-flag", er, 1); chk("err-who", who, 1);
    chk("err-strobe", int'(s2), 0);
    busError = 0; tick();

    // Reset in the middle of an SPU wait, request held across it
    csPins = 14'h0400; dlySPU = 4'd6; cpuReq = 1;
    tick(); tick(); tick();
    nrst = 0; tick();
    @(negedge clk);
    chk("midrst-busy", int'(busy), 0); chk("midrst-ack", int'(cpuAck), 0);
    chk("midrst-strobe", int'(csStrobe), 0);
    @(posedge clk); #1;
    nrst = 1;
    access(1, 0, -1, lat, who, er, sel1, s2);
    chk("midrst-restart-lat", lat, 8);
    tick();

    // Delay input changed during WAIT has no effect
    csPins = 14'h0080; dlyCDRM = 4'd3;
    access(1, 0, 3, lat, who, er, sel1, s2);
    chk("cdrm-lat", lat, 5);
    tick();

    // Randomized traffic checked by the per-cycle model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      gc = cpuAck || cpuErr; gd = dmaAck || dmaErr;
      @(posedge clk); #1;
      if (gc) cpuReq = 0; else if (!cpuReq && $urandom_range(0, 3) == 0) cpuReq = 1;
      if (gd) dmaReq = 0; else if (!dmaReq && $urandom_range(0, 3) == 0) dmaReq = 1;
      if ($urandom_range(0, 9) < 8) csPins = 14'(1) << $urandom_range(0, CS_W - 1);
      else csPins = 14'($urandom);
      busError = ($urandom_range(0, 7) == 0);
      dlyBIOS = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      dlyCDRM = 4'($urandom_range(0, 4));
      dlySPU  = 4'($urandom_range(0, 4));
      dlyExp2 = 4'($urandom_range(0, 4));
      nrst = ($urandom_range(0, 499) != 0);
    end
    nrst = 1; cpuReq = 0; dmaReq = 0;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
